host_frame_parser: RTL

- Byte-wide front end that sits directly upstream of main_core_serialCmd.
- Parses a framed host byte stream into two outputs: command words for the core's cmd/cmd_hasAny/cmd_consume port, and 64-bit data words for its in/in_isReady/in_canReceive port.
- Uses a single holding register, so at most one command or one word is ever pending toward the core.

---
 rtl/host_frame_parser_if.sv | 26 ++
 rtl/host_frame_parser.sv | 126 ++++++++++++
 2 files changed

// File: rtl/host_frame_parser_if.sv
// Host byte-stream handshake plus the command and data-word handshakes toward main_core_serialCmd.
// "master" is the host/core side, "slave" is the parser.
interface host_frame_parser_if #(
   parameter int CMD_W = 16
);
   logic [7:0]       byte_in;
   logic             byte_isReady;
   logic             byte_canReceive;
   logic [CMD_W-1:0] cmd;
   logic             cmd_hasAny;
   logic             cmd_consume;
   logic [63:0]      word_out;
   logic             word_isReady;
   logic             word_canReceive;
   logic             err;

   modport master (
      output byte_in, byte_isReady, cmd_consume, word_canReceive,
      input  byte_canReceive, cmd, cmd_hasAny, word_out, word_isReady, err
   );

   modport slave (
      input  byte_in, byte_isReady, cmd_consume, word_canReceive,
      output byte_canReceive, cmd, cmd_hasAny, word_out, word_isReady, err
   );
endinterface

// File: rtl/host_frame_parser.sv
// Parses framed host bytes into command words and 64-bit data words for main_core_serialCmd.
// A single holding register means at most one command or one word is pending at a time.
module host_frame_parser #(
   parameter int CMD_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   host_frame_parser_if.slave bus
);
   localparam int         CMD_BYTES = (CMD_W + 7) / 8;
   localparam int         IDX_W     = (CMD_BYTES > 8) ? $clog2(CMD_BYTES) : 3;
   localparam logic [7:0] HDR_CMD   = 8'h01;
   localparam logic [7:0] HDR_DATA  = 8'h02;

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_CNT, S_DATA, S_HOLD_CMD, S_HOLD_WORD
   } state_e;

   state_e           state_q;
   logic [IDX_W-1:0] idx_q;
   logic [8:0]       cnt_q;
   logic [CMD_W-1:0] cmd_q;
   logic [63:0]      word_q;
   logic             cmd_valid_q;
   logic             word_valid_q;
   logic             err_q;
   logic             byte_rdy_q;
   logic             byte_fire;

   assign byte_fire = bus.byte_isReady & byte_rdy_q;

   // NOTE: non-blocking assignments only, so every branch reads pre-edge values of all registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: the assembly registers are reset too, because cmd/word_out must read 0 during reset.
         state_q      <= S_IDLE;
         idx_q        <= '0;
         cnt_q        <= '0;
         cmd_q        <= '0;
         word_q       <= '0;
         cmd_valid_q  <= 1'b0;
         word_valid_q <= 1'b0;
         err_q        <= 1'b0;
         byte_rdy_q   <= 1'b1;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (byte_fire) begin
                  if (bus.byte_in == HDR_CMD) begin
                     state_q <= S_CMD;
                     idx_q   <= '0;
                  end else if (bus.byte_in == HDR_DATA) begin
                     state_q <= S_CNT;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            S_CMD: begin
               if (byte_fire) begin
                  // Bits of the last byte that fall above CMD_W have no home and are dropped.
                  for (int i = 0; i < CMD_W; i++) begin
                     if (i / 8 == int'(idx_q)) cmd_q[i] <= bus.byte_in[3'(i % 8)];
                  end
                  if (idx_q == IDX_W'(CMD_BYTES - 1)) begin
                     state_q     <= S_HOLD_CMD;
                     cmd_valid_q <= 1'b1;
                     byte_rdy_q  <= 1'b0;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            S_CNT: begin
               if (byte_fire) begin
                  cnt_q   <= (bus.byte_in == 8'h00) ? 9'd256 : {1'b0, bus.byte_in};
                  idx_q   <= '0;
                  state_q <= S_DATA;
               end
            end
            S_DATA: begin
               if (byte_fire) begin
                  word_q[{idx_q[2:0], 3'b000} +: 8] <= bus.byte_in;
                  if (idx_q[2:0] == 3'd7) begin
                     idx_q        <= '0;
                     state_q      <= S_HOLD_WORD;
                     word_valid_q <= 1'b1;
                     byte_rdy_q   <= 1'b0;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            S_HOLD_CMD: begin
               if (bus.cmd_consume) begin
                  state_q     <= S_IDLE;
                  cmd_valid_q <= 1'b0;
                  byte_rdy_q  <= 1'b1;
               end
            end
            S_HOLD_WORD: begin
               if (bus.word_canReceive) begin
                  cnt_q        <= cnt_q - 9'd1;
                  word_valid_q <= 1'b0;
                  byte_rdy_q   <= 1'b1;
                  state_q      <= (cnt_q == 9'd1) ? S_IDLE : S_DATA;
               end
            end
            default: begin
               state_q      <= S_IDLE;
               cmd_valid_q  <= 1'b0;
               word_valid_q <= 1'b0;
               byte_rdy_q   <= 1'b1;
            end
         endcase
      end
   end

   assign bus.byte_canReceive = byte_rdy_q;
   assign bus.cmd             = cmd_q;
   assign bus.cmd_hasAny      = cmd_valid_q;
   assign bus.word_out        = word_q;
   assign bus.word_isReady    = word_valid_q;
   assign bus.err             = err_q;
endmodule
